// File: rtl/call_stack_if.sv
// Bundle of the call/return control and status signals exchanged between the
// sequencer (master) and the return-address stack (slave).
interface call_stack_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] pc_cur;
  logic          call;
  logic          ret;
  logic [AW-1:0] target;
  logic          err_clr;
  logic [AW-1:0] pc_next;
  logic          pc_load;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          err;

  // Requests are single-cycle strobes sampled at the rising edge; the stack
  // answers combinationally in the same cycle through pc_load/pc_next.
  modport master (
    output pc_cur, call, ret, target, err_clr,
    input  pc_next, pc_load, full, empty, count, err
  );

  modport slave (
    input  pc_cur, call, ret, target, err_clr,
    output pc_next, pc_load, full, empty, count, err
  );
endinterface

// File: rtl/call_stack.sv
// Return-address stack driving a program counter's parallel-load port.
// Optional sticky overflow/underflow flag is built when CALL_STACK_ERR_EN is defined.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  logic         clk,
  input  logic         reset,
  call_stack_if.slave  cs
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [AW-1:0] entry_q [DEPTH];
  logic [AW-1:0] entry_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_m1;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;
  logic [AW-1:0] top;
  logic          full_w;
  logic          empty_w;
  logic          push;
  logic          pop;
  logic          overflow;
  logic          underflow;

  // Call always wins over a simultaneous ret, so ret only acts when call is low.
  always_comb begin
    full_w    = (count_q == CW'(DEPTH));
    empty_w   = (count_q == '0);
    push      = cs.call && !full_w;
    overflow  = cs.call && full_w;
    pop       = cs.ret && !cs.call && !empty_w;
    underflow = cs.ret && !cs.call && empty_w;
  end

  always_comb begin
    count_m1 = count_q - CW'(1);
    top_idx  = count_m1[IW-1:0];
    push_idx = count_q[IW-1:0];
    top      = empty_w ? '0 : entry_q[top_idx];
  end

  // Zero-latency redirect: the PC loads on the same edge the stack updates.
  assign cs.pc_load = cs.call || pop;
  assign cs.pc_next = cs.call ? cs.target : top;
  assign cs.full    = full_w;
  assign cs.empty   = empty_w;
  assign cs.count   = count_q;

  always_comb begin
    count_d = count_q;
    if (push) begin
      count_d = count_q + CW'(1);
    end else if (pop) begin
      count_d = count_m1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (push) begin
      entry_d[push_idx] = cs.pc_cur + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entries beyond count are don't-care, so the array carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

`ifdef CALL_STACK_ERR_EN
  logic err_q;
  logic err_d;

  // A new event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (overflow || underflow) begin
      err_d = 1'b1;
    end else if (cs.err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cs.err = err_q;
`else
  logic unused_err;
  assign unused_err = ^{cs.err_clr, overflow, underflow};
  assign cs.err     = 1'b0;
`endif
endmodule
